// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: raster scan controller for a Sobel edge datapath.
// It sweeps hcount/vcount over a full frame including blanking and flags
// active pixels with dp_en. It re-times the datapath result through a
// PIPE_LAT-deep strobe line into a registered out_pixel/out_valid pair.
// A stop request is honoured at the next frame boundary, followed by a
// drain of PIPE_LAT+1 clocks so in-flight pixels can leave the datapath.
// Optional feature macro: SOBEL_THRESH_EN turns out_pixel into a binary
// edge map (12'hFFF when sobel_value >= thresh, else 12'h000).
module sobel_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int PIPE_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] sobel_value,
  input  logic [11:0] thresh,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        dp_en,
  output logic        out_valid,
  output logic [11:0] out_pixel,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [3:0]  DRAIN_LAST = 4'(PIPE_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [10:0]           hcount_q, hcount_d;
  logic [10:0]           vcount_q, vcount_d;
  logic                  dp_en_q, dp_en_d;
  logic                  stop_pending_q, stop_pending_d;
  logic [3:0]            drain_cnt_q, drain_cnt_d;
  logic [PIPE_LAT-1:0]   dly_q, dly_d;
  logic                  out_valid_q, out_valid_d;
  logic [11:0]           out_pixel_q, out_pixel_d;

  logic [10:0] h_next, v_next;
  logic        h_wrap, frame_last, strobe;
  logic [11:0] proc_value;

  // Raster position one clock ahead, plus the end-of-frame condition.
  assign h_wrap     = (hcount_q == H_LAST);
  assign frame_last = h_wrap && (vcount_q == V_LAST);
  assign h_next     = h_wrap ? 11'd0 : hcount_q + 11'd1;
  assign v_next     = !h_wrap ? vcount_q :
                      (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;

`ifdef SOBEL_THRESH_EN
  assign proc_value = (sobel_value >= thresh) ? 12'hFFF : 12'h000;
`else
  logic unused_thresh;
  assign proc_value    = sobel_value;
  assign unused_thresh = ^thresh;
`endif

  // Next state, counters and stop bookkeeping for IDLE/RUN/DRAIN.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    state_d        = state_q;
    hcount_d       = 11'd0;
    vcount_d       = 11'd0;
    dp_en_d        = 1'b0;
    stop_pending_d = stop_pending_q;
    drain_cnt_d    = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_RUN;
          dp_en_d        = 1'b1;
          stop_pending_d = stop;
        end
      end
      S_RUN: begin
        if (stop) stop_pending_d = 1'b1;
        if (frame_last && (stop_pending_q || stop)) begin
          state_d        = S_DRAIN;
          stop_pending_d = 1'b0;
        end else begin
          hcount_d = h_next;
          vcount_d = v_next;
          dp_en_d  = (h_next < H_ACT) && (v_next < V_ACT);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_IDLE;
        else                           drain_cnt_d = drain_cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe line aligning dp_en with the datapath result, and output capture.
  always_comb begin
    dly_d[0] = dp_en_q;
    for (int i = 1; i < PIPE_LAT; i++) dly_d[i] = dly_q[i-1];
    strobe      = dly_q[PIPE_LAT-1];
    out_valid_d = strobe;
    out_pixel_d = strobe ? proc_value : out_pixel_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      hcount_q       <= 11'd0;
      vcount_q       <= 11'd0;
      dp_en_q        <= 1'b0;
      stop_pending_q <= 1'b0;
      drain_cnt_q    <= 4'd0;
      // NOTE: the strobe line is cleared too, otherwise a pixel in flight at reset would raise out_valid afterwards.
      dly_q          <= '0;
      out_valid_q    <= 1'b0;
      out_pixel_q    <= 12'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      dp_en_q        <= dp_en_d;
      stop_pending_q <= stop_pending_d;
      drain_cnt_q    <= drain_cnt_d;
      dly_q          <= dly_d;
      out_valid_q    <= out_valid_d;
      out_pixel_q    <= out_pixel_d;
    end
  end

  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign dp_en      = dp_en_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign frame_done = (state_q == S_RUN) && frame_last;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a 6x4 raster (4x3 active), PIPE_LAT=2.
// A timeline model (run start cycle, run length in frames, drain length)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_sobel_frame_ctrl;
  localparam int HA = 4, HT = 6, VA = 3, VT = 4, PL = 2;
  localparam int FRAME = HT * VT;
  localparam int INF = 1 << 30;
`ifdef SOBEL_THRESH_EN
  localparam int FIRST_PIX = 0;
`else
  localparam int FIRST_PIX = 100;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [11:0] sobel_value = 12'd0, thresh = 12'd50;
  logic [10:0] hcount, vcount;
  logic        dp_en, out_valid, frame_done, busy;
  logic [11:0] out_pixel;

  sobel_frame_ctrl #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .sobel_value(sobel_value), .thresh(thresh),
    .hcount(hcount), .vcount(vcount), .dp_en(dp_en), .out_valid(out_valid), .out_pixel(out_pixel),
    .frame_done(frame_done), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  bit active = 0;
  int run_t0 = 0, run_len = 0, reset_eff = 0;
  int exp_dp [0:1023];
  int exp_h  [0:1023];
  int dut_h  [0:1023];
  int exp_pix = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0 idle, 1 run, 2 drain, for cycle n under the current timeline.
  function automatic int phase(input int n);
    if (!active || n < run_t0) return 0;
    if (n - run_t0 < run_len) return 1;
    if (n - run_t0 < run_len + PL + 1) return 2;
    return 0;
  endfunction

  function automatic int pix_src(input int h);
`ifdef SOBEL_THRESH_EN
    return (h % 2 == 1) ? 50 : 49;
`else
    return 100 + h;
`endif
  endfunction

  function automatic int proc_val(input int v);
`ifdef SOBEL_THRESH_EN
    return (v >= 50) ? 4095 : 0;
`else
    return v;
`endif
  endfunction

  // Model update from the inputs sampled at this edge (cycle cyc).
  always @(posedge clk) begin
    if (rst) begin
      active = 0;
      reset_eff = cyc + 1;
    end else if (phase(cyc) == 0 && start) begin
      active = 1;
      run_t0 = cyc + 1;
      run_len = stop ? FRAME : INF;
    end else if (phase(cyc) == 1 && stop && run_len == INF) begin
      run_len = ((cyc - run_t0) / FRAME + 1) * FRAME;
    end
    cyc = cyc + 1;
  end

  // Per-cycle compare against the model; also emulates the datapath delay.
  always @(negedge clk) begin : cmp
    int n, ph, rel, eh, ev, edp, efd, eov;
    n = cyc;
    if (n >= 1 && n < 1024) begin
      ph = phase(n);
      rel = n - run_t0;
      eh = 0; ev = 0; edp = 0; efd = 0;
      if (ph == 1) begin
        eh = rel % HT;
        ev = (rel / HT) % VT;
        edp = (eh < HA && ev < VA) ? 1 : 0;
        efd = (eh == HT - 1 && ev == VT - 1) ? 1 : 0;
      end
      exp_dp[n] = edp;
      exp_h[n] = eh;
      eov = (n >= reset_eff + PL + 1) ? exp_dp[n-PL-1] : 0;
      if (n <= reset_eff) exp_pix = 0;
      else if (eov != 0) exp_pix = proc_val(pix_src(exp_h[n-PL-1]));
      check("hcount", int'(hcount), eh);
      check("vcount", int'(vcount), ev);
      check("dp_en", int'(dp_en), edp);
      check("frame_done", int'(frame_done), efd);
      check("busy", int'(busy), (ph != 0) ? 1 : 0);
      check("out_valid", int'(out_valid), eov);
      check("out_pixel", int'(out_pixel), exp_pix);
      dut_h[n] = int'(hcount);
      sobel_value = (n >= PL + 1) ? 12'(pix_src(dut_h[n-PL])) : 12'd0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check("busy_drops_in_bound", int'(busy), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dpc, fdc, fd_first, fd_second, n, ovc;
    // Reset.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_hcount", int'(hcount), 0);
    check("rst_dp_en", int'(dp_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);

    // Continuous streaming, start in RUN ignored, first result timing.
    start = 1'b1; step(); start = 1'b0;
    check("first_h", int'(hcount), 0);
    check("first_v", int'(vcount), 0);
    check("first_dp", int'(dp_en), 1);
    dpc = 0; fdc = 0; fd_first = -1; fd_second = -1;
    for (int i = 0; i < 48; i++) begin
      if (i < 24 && dp_en) dpc++;
      if (frame_done) begin
        fdc++;
        if (fd_first < 0) fd_first = i; else fd_second = i;
      end
      if (i == 2) check("ov_not_early", int'(out_valid), 0);
      if (i == 3) begin
        check("ov_trail_3", int'(out_valid), 1);
        check("first_pixel", int'(out_pixel), FIRST_PIX);
      end
`ifdef SOBEL_THRESH_EN
      if (i == 4) check("second_pixel", int'(out_pixel), 4095);
`endif
      start = (i == 10);
      step();
    end
    start = 1'b0;
    check("dp_per_frame", dpc, 12);
    check("fd_count", fdc, 2);
    check("fd_first", fd_first, 23);
    check("fd_second", fd_second, 47);
    check("wrap_no_gap", int'(dp_en), 1);
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(n);

    // Stop at clock 5 of frame 1: busy lasts 24 + 3 clocks.
    repeat (2) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(n);
    check("busy_len", 6 + n, 27);
    check("idle_h", int'(hcount), 0);
    check("idle_dp", int'(dp_en), 0);

    // start and stop together: exactly one frame.
    repeat (2) step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    ovc = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) ovc++;
      step();
    end
    check("one_frame_ov", ovc, 12);
    check("one_frame_idle", int'(busy), 0);

    // Reset mid-frame at (2,1), overriding a simultaneous start.
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!(hcount == 11'd2 && vcount == 11'd1) && n < 40) begin n++; step(); end
    check("reach_2_1", (n < 40) ? 1 : 0, 1);
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    check("midrst_h", int'(hcount), 0);
    check("midrst_v", int'(vcount), 0);
    check("midrst_dp", int'(dp_en), 0);
    check("midrst_ov", int'(out_valid), 0);
    check("midrst_pix", int'(out_pixel), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (4) step();
    start = 1'b1; step(); start = 1'b0;
    check("restart_h", int'(hcount), 0);
    check("restart_v", int'(vcount), 0);
    check("restart_dp", int'(dp_en), 1);

    // Reset during DRAIN.
    stop = 1'b1; step(); stop = 1'b0;
    n = 0;
    while (!frame_done && n < 40) begin n++; step(); end
    check("reach_frame_end", (n < 40) ? 1 : 0, 1);
    step();
    check("drain_busy", int'(busy), 1);
    check("drain_dp", int'(dp_en), 0);
    rst = 1'b1; step(); rst = 1'b0;
    check("drainrst_busy", int'(busy), 0);
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
